// File: rtl/countdown_timer_overlay.sv
// rtl/countdown_timer_overlay.sv - game countdown timer with registered time-bar overlay pixels
`timescale 1ns/1ps

module countdown_timer_overlay #(
  parameter int CLK_HZ     = 25000000,
  parameter int START_SECS = 30,
  parameter int WARN_SECS  = 10,
  parameter int BAR_X      = 20,
  parameter int BAR_Y      = 8,
  parameter int BAR_H      = 8,
  parameter int SEG_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       video_on,
  output logic       r_timer,
  output logic       g_timer,
  output logic       b_timer,
  output logic [5:0] time_left,
  output logic       expired
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  localparam logic [PW-1:0] PRESC_MAX  = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(CLK_HZ / 2);
  localparam logic [5:0]    START_V    = 6'(START_SECS);
  localparam logic [5:0]    WARN_V     = 6'(WARN_SECS);
  localparam logic [11:0]   BAR_X_V    = 12'(BAR_X);
  localparam logic [11:0]   BAR_Y_V    = 12'(BAR_Y);
  localparam logic [11:0]   BAR_Y_END  = 12'(BAR_Y + BAR_H);
  localparam logic [11:0]   SEG_W_V    = 12'(SEG_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    time_left_q, time_left_d;
  logic          expired_q, expired_d;
  logic          r_q, r_d;
  logic          g_q, g_d;

  logic          tick;
  logic          blink_on;
  logic [5:0]    secs_sel;
  logic [11:0]   h_ext;
  logic [11:0]   v_ext;
  logic [11:0]   bar_len;
  logic [11:0]   bar_x_end;
  logic          row_hit;
  logic          col_hit;

  // Next-state for the timer FSM, prescaler and remaining seconds
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    time_left_d = time_left_q;
    tick        = (presc_q == PRESC_MAX);
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // pause wins over start and over a tick landing in the same cycle
        if (pause) begin
          state_d = PAUSED;
        end else if (tick) begin
          presc_d = '0;
          if (time_left_q > 6'd1) begin
            time_left_d = time_left_q - 6'd1;
          end else begin
            time_left_d = 6'd0;
            state_d     = EXPIRED;
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      PAUSED: begin
        // prescaler keeps its value so the current second resumes where it stopped
        if (start && !pause) begin
          state_d = RUN;
        end
      end
      EXPIRED: begin
        presc_d = '0;
        if (start) begin
          state_d     = RUN;
          time_left_d = START_V;
        end
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase
    expired_d = (state_d == EXPIRED);
  end

  // Bar geometry and colour selection for the pixel presented this cycle
  always_comb begin
    h_ext     = {2'b00, hcount};
    v_ext     = {2'b00, vcount};
    secs_sel  = (state_q == EXPIRED) ? START_V : time_left_q;
    bar_len   = 12'(secs_sel) * SEG_W_V;
    bar_x_end = BAR_X_V + bar_len;
    row_hit   = (v_ext >= BAR_Y_V) && (v_ext < BAR_Y_END);
    col_hit   = (h_ext >= BAR_X_V) && (h_ext < bar_x_end);
    blink_on  = (presc_q < PRESC_HALF);
    r_d       = 1'b0;
    g_d       = 1'b0;
    if (row_hit && col_hit && video_on) begin
      if (state_q == EXPIRED) begin
        r_d = 1'b1;
      end else if (time_left_q > WARN_V) begin
        g_d = 1'b1;
      end else if (time_left_q != 6'd0) begin
        // warning band blinks only while the clock is actually running
        if ((state_q != RUN) || blink_on) begin
          r_d = 1'b1;
          g_d = 1'b1;
        end
      end
    end
  end

  // Timer state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      time_left_q <= START_V;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      time_left_q <= time_left_d;
      expired_q   <= expired_d;
    end
  end

  // Pixel output registers, one cycle behind hcount/vcount/video_on
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= 1'b0;
      g_q <= 1'b0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
    end
  end

  assign r_timer   = r_q;
  assign g_timer   = g_q;
  assign b_timer   = 1'b0;
  assign time_left = time_left_q;
  assign expired   = expired_q;

endmodule
